// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard arbiter (freeze/flush/stall/run) with saturating event counters.
module hazard_ctrl #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [6:0]                IF_ID_inst_opcode,
  input  logic [REG_ADDR_WIDTH-1:0] IF_ID_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] IF_ID_rs2,
  input  logic [6:0]                ID_EX_inst_opcode,
  input  logic [REG_ADDR_WIDTH-1:0] ID_EX_rd,
  input  logic                      branch_taken,
  input  logic                      mem_busy,
  input  logic                      perf_clr,
  output logic                      pc_write_en,
  output logic                      IF_ID_write_en,
  output logic                      IF_ID_flush,
  output logic                      ctr_sel,
  output logic                      ID_EX_hold,
  output logic [1:0]                hazard_state,
  output logic [CNT_WIDTH-1:0]      stall_cycles,
  output logic [CNT_WIDTH-1:0]      flush_cycles
);
  typedef enum logic [1:0] {RUN = 2'b00, STALL = 2'b01, FLUSH = 2'b10, FREEZE = 2'b11} act_t;
  act_t act;
  logic pend_flush, uses_rs1, uses_rs2, load_use;
  assign uses_rs1 = !(IF_ID_inst_opcode inside {7'b0110111, 7'b0010111, 7'b1101111});
  assign uses_rs2 = IF_ID_inst_opcode inside {7'b0110011, 7'b0100011, 7'b1100011};
  assign load_use = (ID_EX_inst_opcode == 7'b0000011) && (ID_EX_rd != '0) &&
                    ((uses_rs1 && ID_EX_rd == IF_ID_rs1) || (uses_rs2 && ID_EX_rd == IF_ID_rs2));
  // a redirect seen while frozen is replayed as soon as memory is ready
  assign act = mem_busy ? FREEZE : (branch_taken || pend_flush) ? FLUSH : load_use ? STALL : RUN;
  assign pc_write_en    = !reset && (act == RUN || act == FLUSH);
  assign IF_ID_write_en = !reset && (act == RUN || act == FLUSH);
  assign IF_ID_flush    = reset || act == FLUSH;
  assign ctr_sel        = !reset && (act == RUN || act == FREEZE);
  assign ID_EX_hold     = !reset && act == FREEZE;
  always_ff @(posedge clk) begin
    if (reset) begin
      hazard_state <= 2'b00;
      pend_flush   <= 1'b0;
      stall_cycles <= '0;
      flush_cycles <= '0;
    end else begin
      hazard_state <= act;
      pend_flush   <= (act == FREEZE) ? (pend_flush || branch_taken) : (act == FLUSH) ? 1'b0 : pend_flush;
      if (perf_clr) stall_cycles <= '0;
      else if ((act == FREEZE || act == STALL) && !(&stall_cycles)) stall_cycles <= stall_cycles + CNT_WIDTH'(1);
      if (perf_clr) flush_cycles <= '0;
      else if (act == FLUSH && !(&flush_cycles)) flush_cycles <= flush_cycles + CNT_WIDTH'(1);
    end
  end
endmodule
